// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: initiator FSM states and the RV32M decode constants
// used when building or recognising MUL/DIV instructions on the PCPI bus.
package pcpi_pkg;

    localparam int       PCPI_XLEN     = 32;
    localparam bit [6:0] OPCODE_OP     = 7'b0110011;
    localparam bit [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/pcpi_issue.sv
// PCPI initiator: takes one instruction from the core, presents it on the PCPI
// bus until a coprocessor answers (or nobody does), then hands back the result
// or an illegal-instruction trap. Only one request is ever in flight.
module pcpi_issue
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TRAPCNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PCPI_XLEN-1:0] req_insn,
    input  logic [PCPI_XLEN-1:0] req_rs1,
    input  logic [PCPI_XLEN-1:0] req_rs2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_wr,
    output logic [PCPI_XLEN-1:0] resp_rd,
    output logic                 resp_trap,
    output logic                 pcpi_valid,
    output logic [PCPI_XLEN-1:0] pcpi_insn,
    output logic [PCPI_XLEN-1:0] pcpi_rs1,
    output logic [PCPI_XLEN-1:0] pcpi_rs2,
    input  logic                 pcpi_wr,
    input  logic [PCPI_XLEN-1:0] pcpi_rd,
    input  logic                 pcpi_wait,
    input  logic                 pcpi_ready,
    output logic [TRAPCNT_W-1:0] trap_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic          accept;
    logic          fire_ready;
    logic          fire_timeout;

    // Responder handshake only matters while issuing; ready wins over timeout.
    assign accept       = (state == IDLE) && req_valid;
    assign fire_ready   = (state == ISSUE) && pcpi_ready;
    assign fire_timeout = (state == ISSUE) && !pcpi_ready && !pcpi_wait && (tcnt == TCNT_LAST);

    // State register; every flop output below is decoded from it, so
    // pcpi_valid is glitch-free and drops for at least the RESP cycle.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        pcpi_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                pcpi_valid = 1'b1;
                if (fire_ready || fire_timeout) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, timeout counter, response latch and trap statistics.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            tcnt       <= '0;
            resp_wr    <= 1'b0;
            resp_rd    <= '0;
            resp_trap  <= 1'b0;
            trap_count <= '0;
        end else begin
            if (accept) begin
                pcpi_insn <= req_insn;
                pcpi_rs1  <= req_rs1;
                pcpi_rs2  <= req_rs2;
                tcnt      <= '0;
            end
            if (fire_ready) begin
                resp_wr   <= pcpi_wr;
                resp_rd   <= pcpi_rd;
                resp_trap <= 1'b0;
            end else if (fire_timeout) begin
                resp_wr   <= 1'b0;
                resp_rd   <= '0;
                resp_trap <= 1'b1;
                if (trap_count != '1) trap_count <= trap_count + 1'b1;
            end else if (state == ISSUE) begin
                // A busy responder restarts the window; it can never trap.
                if (pcpi_wait) tcnt <= '0;
                else           tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule
